// File: rtl/fir_out_fp16_pack.sv
// FIR output stage: captures a raw FP29i accumulator sample, normalizes it one
// bit per cycle, rounds it to IEEE FP16 (RNE) and offers it on a valid/ready port.
module fir_out_fp16_pack #(
  parameter int IN_BIAS   = 15,
  parameter int MAN_FRAC  = 20,
  parameter int MAX_SHIFT = 21
) (
  input  logic        clk_fast,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [28:0] in_29i,
  input  logic        out_ready,
  input  logic        clr_flags,
  output logic [15:0] out_fp16,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun,
  output logic        ovf,
  output logic        unf
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  localparam int EXP_ADJ = 15 - IN_BIAS + 21 - MAN_FRAC;
  localparam logic signed [9:0] EXP_ADJ10 = 10'(EXP_ADJ);

  state_t      state_q;
  logic        in_valid_q;
  logic        s_q;
  logic [5:0]  e_q;
  logic [21:0] m_q;
  logic [4:0]  n_q;
  logic [15:0] res_q;
  logic        ovf_ev_q, unf_ev_q;
  logic [15:0] out_q;
  logic        out_valid_q, busy_q, overrun_q, ovf_q, unf_q;

  logic        capture;
  logic        norm_done;
  logic        drop_ev;

  logic signed [9:0] exp16;
  logic [9:0]  neg;
  logic [4:0]  sh1;
  logic [43:0] m_ext;
  logic [4:0]  fexp;
  logic [9:0]  frac;
  logic        guard, sticky, inc;
  logic [14:0] rsum;
  logic [15:0] res_d;
  logic        ovf_ev_d, unf_ev_d;

  assign capture   = in_valid & ~in_valid_q;
  assign norm_done = (m_q == '0) || m_q[21] || (n_q == 5'(MAX_SHIFT));
  assign drop_ev   = (capture && state_q != IDLE) ||
                     (state_q == OUT && out_valid_q && !out_ready);

  always_comb begin
    exp16    = $signed({4'b0, e_q}) + EXP_ADJ10 - $signed({5'b0, n_q});
    neg      = -exp16;
    sh1      = '0;
    m_ext    = '0;
    fexp     = '0;
    frac     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    ovf_ev_d = 1'b0;
    unf_ev_d = 1'b0;
    if (exp16 >= 10'sd1) begin
      frac   = m_q[20:11];
      guard  = m_q[10];
      sticky = |m_q[9:0];
      fexp   = (exp16 >= 10'sd31) ? 5'd31 : exp16[4:0];
    end else begin
      // {M,22'b0} >> (1-exp16-1) keeps every shifted-out bit for the sticky OR
      sh1    = (neg > 10'd22) ? 5'd22 : neg[4:0];
      m_ext  = {m_q, 22'b0} >> sh1;
      frac   = m_ext[43:34];
      guard  = m_ext[33];
      sticky = |m_ext[32:0];
    end
    inc  = guard & (sticky | frac[0]);
    rsum = {fexp, frac} + {14'b0, inc};
    if (m_q == '0) begin
      res_d = {s_q, 15'b0};
    end else if (fexp == 5'd31 || rsum[14:10] == 5'h1F) begin
      res_d    = {s_q, 5'h1F, 10'h0};
      ovf_ev_d = 1'b1;
    end else begin
      res_d    = {s_q, rsum};
      unf_ev_d = (rsum[14:10] == 5'd0);
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_valid_q  <= 1'b0;
      s_q         <= 1'b0;
      e_q         <= '0;
      m_q         <= '0;
      n_q         <= '0;
      res_q       <= '0;
      ovf_ev_q    <= 1'b0;
      unf_ev_q    <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      in_valid_q <= in_valid;
      ovf_ev_q   <= 1'b0;
      unf_ev_q   <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (capture) begin
          s_q     <= in_29i[28];
          e_q     <= in_29i[27:22];
          m_q     <= in_29i[21:0];
          n_q     <= '0;
          state_q <= NORM;
          busy_q  <= 1'b1;
        end
        NORM: if (norm_done) begin
          state_q <= ROUND;
        end else begin
          m_q <= m_q << 1;
          n_q <= n_q + 5'd1;
        end
        ROUND: begin
          res_q    <= res_d;
          ovf_ev_q <= ovf_ev_d;
          unf_ev_q <= unf_ev_d;
          state_q  <= OUT;
        end
        OUT: begin
          if (!out_valid_q || out_ready) begin
            out_q       <= res_q;
            out_valid_q <= 1'b1;
          end
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      // set events take priority over a simultaneous clear
      overrun_q <= (overrun_q & ~clr_flags) | drop_ev;
      ovf_q     <= (ovf_q & ~clr_flags) | ovf_ev_q;
      unf_q     <= (unf_q & ~clr_flags) | unf_ev_q;
    end
  end

  assign out_fp16  = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

endmodule

// File: tb/tb_fir_out_fp16_pack.sv
// Directed bench for fir_out_fp16_pack: hand-computed FP16 results, latencies,
// flag behaviour, backpressure and mid-conversion reset.
module tb_fir_out_fp16_pack;

  logic        clk_fast = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [28:0] in_29i = '0;
  logic        out_ready = 1'b0;
  logic        clr_flags = 1'b0;
  logic [15:0] out_fp16;
  logic        out_valid, busy, overrun, ovf, unf;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        s;
    logic [5:0]  e;
    logic [21:0] m;
    logic [15:0] fp;
    logic [5:0]  lat;
    logic        ovf;
    logic        unf;
  } vec_t;

  fir_out_fp16_pack #(.IN_BIAS(15), .MAN_FRAC(20), .MAX_SHIFT(21)) dut (
    .clk_fast  (clk_fast),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_29i    (in_29i),
    .out_ready (out_ready),
    .clr_flags (clr_flags),
    .out_fp16  (out_fp16),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk_fast = ~clk_fast;

  // Raise in_valid for one cycle; returns at the negedge after capture edge k.
  task automatic send(input logic s, input logic [5:0] e, input logic [21:0] m);
    @(negedge clk_fast);
    in_29i   = {s, e, m};
    in_valid = 1'b1;
    @(posedge clk_fast);
    @(negedge clk_fast);
    in_valid = 1'b0;
  endtask

  // Sends a sample, measures capture-to-valid latency (-1 on timeout),
  // grabs the result and optionally accepts it.
  task automatic run_conv(input logic s, input logic [5:0] e, input logic [21:0] m,
                          input logic accept, output logic [15:0] fp, output int lat);
    send(s, e, m);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk_fast);
      lat++;
    end
    if (!out_valid) lat = -1;
    fp = out_fp16;
    if (accept) begin
      out_ready = 1'b1;
      @(negedge clk_fast);
      out_ready = 1'b0;
    end
  endtask

  task automatic clear_flags();
    @(negedge clk_fast);
    clr_flags = 1'b1;
    @(negedge clk_fast);
    clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_fast);
    checks++;
    if ({out_fp16, out_valid, busy, overrun, ovf, unf} !== 21'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 0", {out_fp16, out_valid, busy, overrun, ovf, unf});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk_fast);
  endtask

  task automatic test_one();
    logic [15:0] fp;
    int lat;
    run_conv(1'b0, 6'd15, 22'h100000, 1'b1, fp, lat);
    checks++;
    if (fp !== 16'h3C00) begin errors++; $display("FAIL one_value got %h exp 3c00", fp); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL one_latency got %0d exp 4", lat); end
    checks++;
    if ({overrun, ovf, unf} !== 3'b000) begin
      errors++; $display("FAIL one_flags got %b exp 000", {overrun, ovf, unf});
    end
  endtask

  task automatic test_rounding();
    logic [21:0] m_tbl [3];
    logic [15:0] fp_tbl [3];
    logic [15:0] fp;
    int lat;
    m_tbl[0] = 22'h100200; fp_tbl[0] = 16'h3C00;
    m_tbl[1] = 22'h100201; fp_tbl[1] = 16'h3C01;
    m_tbl[2] = 22'h100600; fp_tbl[2] = 16'h3C02;
    for (int i = 0; i < 3; i++) begin
      run_conv(1'b0, 6'd15, m_tbl[i], 1'b1, fp, lat);
      checks++;
      if (fp !== fp_tbl[i]) begin
        errors++; $display("FAIL round_%0d got %h exp %h", i, fp, fp_tbl[i]);
      end
      checks++;
      if (lat != 4) begin errors++; $display("FAIL round_lat_%0d got %0d exp 4", i, lat); end
    end
  endtask

  task automatic run_table(input string name, input vec_t tbl [], input int n);
    logic [15:0] fp;
    int lat;
    for (int i = 0; i < n; i++) begin
      clear_flags();
      run_conv(tbl[i].s, tbl[i].e, tbl[i].m, 1'b1, fp, lat);
      checks++;
      if (fp !== tbl[i].fp) begin
        errors++; $display("FAIL %s_value_%0d got %h exp %h", name, i, fp, tbl[i].fp);
      end
      checks++;
      if (lat != int'(tbl[i].lat)) begin
        errors++; $display("FAIL %s_latency_%0d got %0d exp %0d", name, i, lat, tbl[i].lat);
      end
      checks++;
      if ({ovf, unf} !== {tbl[i].ovf, tbl[i].unf}) begin
        errors++; $display("FAIL %s_flags_%0d got %b exp %b", name, i, {ovf, unf}, {tbl[i].ovf, tbl[i].unf});
      end
    end
  endtask

  task automatic test_range();
    vec_t tbl [];
    tbl = new[7];
    tbl[0] = '{1'b1, 6'd40, 22'h200000, 16'hFC00, 6'd3,  1'b1, 1'b0};
    tbl[1] = '{1'b0, 6'd1,  22'h100000, 16'h0400, 6'd4,  1'b0, 1'b0};
    tbl[2] = '{1'b0, 6'd0,  22'h100000, 16'h0200, 6'd4,  1'b0, 1'b1};
    tbl[3] = '{1'b0, 6'd15, 22'h000001, 16'h0010, 6'd24, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 6'd29, 22'h3FFFFF, 16'h7C00, 6'd3,  1'b1, 1'b0};
    tbl[5] = '{1'b0, 6'd0,  22'h1FFFFF, 16'h0400, 6'd4,  1'b0, 1'b0};
    tbl[6] = '{1'b0, 6'd63, 22'h200000, 16'h7C00, 6'd3,  1'b1, 1'b0};
    run_table("range", tbl, 7);
  endtask

  task automatic test_zero_sign();
    vec_t tbl [];
    tbl = new[2];
    tbl[0] = '{1'b1, 6'd20, 22'h000000, 16'h8000, 6'd3,  1'b0, 1'b0};
    tbl[1] = '{1'b0, 6'd35, 22'h000001, 16'h3C00, 6'd24, 1'b0, 1'b0};
    run_table("zero", tbl, 2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] fp;
    int lat;
    int cyc;
    clear_flags();
    run_conv(1'b0, 6'd15, 22'h100000, 1'b0, fp, lat);
    send(1'b0, 6'd15, 22'h100201);
    cyc = 0;
    while (busy && cyc < 60) begin @(negedge clk_fast); cyc++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle got busy=%b exp 0", busy); end
    checks++;
    if ({out_valid, out_fp16} !== {1'b1, 16'h3C00}) begin
      errors++; $display("FAIL bp_retained got %b/%h exp 1/3c00", out_valid, out_fp16);
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL bp_overrun got %b exp 1", overrun); end
    clear_flags();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL bp_clear got %b exp 0", overrun); end
    out_ready = 1'b1;
    @(negedge clk_fast);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got %b exp 0", out_valid); end
  endtask

  task automatic test_capture_busy();
    logic [15:0] fp;
    int cyc;
    clear_flags();
    send(1'b0, 6'd15, 22'h000001);
    send(1'b0, 6'd15, 22'h100000);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL busy_overrun got %b exp 1", overrun); end
    cyc = 0;
    while (!out_valid && cyc < 60) begin @(negedge clk_fast); cyc++; end
    fp = out_fp16;
    checks++;
    if ({out_valid, fp} !== {1'b1, 16'h0010}) begin
      errors++; $display("FAIL busy_result got %b/%h exp 1/0010", out_valid, fp);
    end
    out_ready = 1'b1;
    @(negedge clk_fast);
    out_ready = 1'b0;
    repeat (6) @(negedge clk_fast);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL busy_no_second got %b exp 00", {out_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] fp;
    int lat;
    send(1'b0, 6'd15, 22'h000001);
    repeat (3) @(negedge clk_fast);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_fp16, out_valid, busy, overrun, ovf, unf} !== 21'h0) begin
      errors++; $display("FAIL rst_mid_async got %h exp 0", {out_fp16, out_valid, busy, overrun, ovf, unf});
    end
    @(negedge clk_fast);
    rst_n = 1'b1;
    repeat (30) @(negedge clk_fast);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL rst_mid_stale got %b exp 00", {out_valid, busy});
    end
    run_conv(1'b0, 6'd15, 22'h100600, 1'b1, fp, lat);
    checks++;
    if (fp !== 16'h3C02) begin errors++; $display("FAIL rst_mid_next got %h exp 3c02", fp); end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL rst_mid_lat got %0d exp 4", lat); end
  endtask

  initial begin
    test_reset();
    test_one();
    test_rounding();
    test_range();
    test_zero_sign();
    test_back_to_back();
    test_capture_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_out_fp16_pack.md
Name: fir_out_fp16_pack

Overview:
- Output stage placed directly downstream of the W4823 FIR datapath.
- Captures the raw 29-bit FP29i accumulator result when the FIR asserts its output-valid level.
- Normalizes it iteratively, rebiases it and rounds it round-to-nearest-even to IEEE FP16.
- Presents the FP16 result on a valid/ready output port with sticky status flags.

Parameters:
IN_BIAS, 15, exponent bias of the FP29i exponent field
MAN_FRAC, 20, fraction bits of the FP29i mantissa: value = (-1)^S x M x 2^(E-IN_BIAS-MAN_FRAC)
MAX_SHIFT, 21, maximum normalization shifts (mantissa width - 1)

Ports:
clk_fast  in  1  fast clock, all logic on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  FIR result-valid level; a new sample is taken on each 0->1 transition
in_29i  in  29  FP29i: [28] sign S, [27:22] exponent E (unsigned), [21:0] mantissa M (unsigned, not normalized)
out_ready  in  1  consumer accepts out_fp16 when high with out_valid
clr_flags  in  1  synchronous clear of overrun/ovf/unf
out_fp16  out  16  IEEE FP16 result
out_valid  out  1  result held until accepted
busy  out  1  conversion in progress (state != IDLE)
overrun  out  1  sticky: a sample or result was dropped
ovf  out  1  sticky: a result saturated to +/-inf
unf  out  1  sticky: a nonzero input produced a subnormal or zero

Behaviour:
- Reset: all outputs 0; FSM = IDLE; in_valid edge-detect register = 0.
- Edge detect: in_valid_d is registered every cycle. A capture occurs at posedge k when in_valid=1 and in_valid_d=0.
- FSM states: IDLE, NORM, ROUND, OUT.
- IDLE -> NORM on capture. Latch S, E and M. Clear shift count N.
- NORM, per cycle:
  - If M==0 or M[21]==1 or N==MAX_SHIFT: go to ROUND.
  - Otherwise: M <= M<<1 and N <= N+1.
  - A zero mantissa makes no shifts.
- ROUND, single cycle, combinational into the result register:
  - Compute signed 9-bit exp16 = E - IN_BIAS + 15 + (21 - MAN_FRAC) - N. With the default parameters this is E+1-N.
  - Zero: if M==0, result = {S, 15'b0}. No flag.
  - Normal: if exp16 >= 1, frac = M[20:11], guard = M[10], sticky = |M[9:0].
  - Subnormal: if exp16 <= 0, right-shift the 22-bit M by (1-exp16), capped at 23, before extracting. Bits shifted out OR into sticky. The field exponent is 0.
  - RNE rounding: increment when guard & (sticky | frac[0]).
    - A carry out of frac increments the exponent field.
    - Max subnormal rounds up to 0x0400.
    - 0x7BFF rounds up to 0x7C00.
  - Overflow: if the field exponent is >= 31 before or after rounding, result = {S, 5'h1F, 10'h0} and ovf is set.
  - Underflow: unf is set when M!=0 and the field exponent ends at 0, whether the result is subnormal or zero.
- ROUND -> OUT.
  - If out_valid=0: load out_fp16 and set out_valid.
  - If out_valid=1 and out_ready=0: drop the new result and set overrun.
  - A handshake in that same cycle frees the slot, and the new result loads.
- OUT -> IDLE next cycle.
- Latency: out_valid goes high after posedge k+3+N, where k is the capture edge and N is in 0..21.
- Output handshake:
  - out_fp16 is held stable while out_valid=1.
  - out_valid clears on the posedge where out_valid & out_ready.
- Capture while busy: the in_valid rising edge is ignored and overrun is set. An ongoing conversion is unaffected.
- Flags:
  - clr_flags clears the flags the same cycle.
  - A set event in the same cycle wins over the clear.
- Reset mid-operation aborts the conversion immediately. No partial result appears.
- Exponent arithmetic uses at least 9-bit signed width. E=63 with N=0 must not wrap.

Test Plan:
- One (E=15, M=0x100000, S=0): capture at k -> N=1, out_fp16=0x3C00, out_valid after k+4.
- Rounding, all with E=15:
  - M=0x100200 (exact tie, even) -> 0x3C00.
  - M=0x100201 -> 0x3C01.
  - M=0x100600 (tie, odd) -> 0x3C02.
- Range:
  - E=40, M=0x200000, S=1 -> 0xFC00 and ovf=1.
  - E=1, M=0x100000 -> 0x0400, unf=0.
  - E=0, M=0x100000 -> 0x0200, unf=1.
  - E=15, M=1, S=0 -> 2^-20, subnormal -> 0x0010, unf=1.
- Zero/sign: M=0 with S=1 -> 0x8000 at k+3, no flags. M=0x000001 with E=35 -> N=21, 1.0 -> 0x3C00 at k+24.
- Backpressure:
  - Hold out_ready=0 and produce two results -> first result retained, second dropped, overrun=1.
  - clr_flags -> overrun=0.
  - A second in_valid edge during NORM -> ignored, overrun=1.
- Reset: assert rst_n=0 during NORM -> all outputs 0 asynchronously; after release, no stale out_valid; the next capture converts correctly.
